rggen_bit_field_counter: RTL
============================

Name: rggen_bit_field_counter

Overview:
Software-accessible event counter bit field; successor of the write/read-clear bit field, generalised in clear mode, increment width and overflow policy. Sits behind the register decoder on rggen_bit_field_if like any bit field, and counts hardware events. Software can read it, optionally clear it on read, and overwrite it with masked writes. Wrap or saturate is chosen by parameter, and a sticky overflow flag records lost counts.

Parameters:
WIDTH, 8, counter/bit field width; 1..64.
INITIAL_VALUE, '0 (WIDTH bits), value loaded on reset and on i_clear.
INC_WIDTH, 1, width of i_increment; 1..WIDTH.
CLEAR_ON_READ, 1, 1: any read access clears the counter; 0: reads are non-destructive.
SATURATE, 0, 0: wrap modulo 2^WIDTH on overflow; 1: clamp at all-ones on overflow.

Ports:
i_clk  input  1  clock; all state updates on posedge.
i_rst_n  input  1  reset; synchronous, active-low, sampled on posedge i_clk.
bit_field_if  interface  rggen_bit_field_if.bit_field  software access (valid, read_mask, write_mask, write_data in; read_data, value out).
i_clear  input  1  hardware clear strobe.
i_event  input  1  count-enable strobe.
i_increment  input  INC_WIDTH  amount added when i_event=1; zero-extended to WIDTH+1.
o_value  output  WIDTH  current counter value.
o_overflow  output  1  sticky overflow flag.

Behaviour:
- State: value[WIDTH-1:0] and overflow flag. bit_field_if.value, bit_field_if.read_data and o_value all equal value. Outputs are registered; there is no combinational path from inputs to outputs.
- Reset: on a posedge with i_rst_n=0, value=INITIAL_VALUE and o_overflow=0. All other inputs are ignored that cycle. Reset is honoured mid-access; the access is discarded.
- Access decode:
  - Read access: valid && read_mask!='0.
  - Write access: valid && write_mask!='0 && read_mask=='0.
- Per-cycle base value, in priority order:
  1. i_clear=1: base=INITIAL_VALUE. Any i_event that cycle is discarded. Overflow cleared.
  2. Read access && CLEAR_ON_READ=1: base='0, overflow cleared.
  3. Write access: base=(write_data & write_mask) | (value & ~write_mask). Overflow unchanged.
  4. Otherwise: base=value.
- Event add, not applied under i_clear:
  - sum = {1'b0,base} + (i_event ? zext(i_increment) : 0), computed in WIDTH+1 bits.
  - sum[WIDTH]=0: value<=sum[WIDTH-1:0].
  - sum[WIDTH]=1, SATURATE=0: value<=sum[WIDTH-1:0] (wrap) and overflow<=1.
  - sum[WIDTH]=1, SATURATE=1: value<='1 and overflow<=1.
- Simultaneous read-clear and event: read_data returns the pre-clear value; the new value is the increment, so no event is lost.
- Simultaneous write and event: the event adds on top of the written value.
- An overflow set and an overflow clear in the same cycle cannot coincide: a cleared base of 0 cannot overflow because INC_WIDTH<=WIDTH.
- i_event=1 with i_increment=0: no change.
- Latency: every effect is visible one cycle after the sampling edge.

Optional Feature:
Macro RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN.
- Defined:
  - Adds port i_threshold (input, WIDTH) and port o_threshold_hit (output, 1).
  - o_threshold_hit is registered and set to 1 on the cycle the next value becomes >= i_threshold while the current value < i_threshold (rising crossing only). It is a single-cycle pulse.
  - It is 0 on reset and never pulses on i_clear or on read-clear.
  - A software write that crosses the threshold does pulse it.
- Undefined: neither port exists and no threshold logic is synthesised.

Test Plan:
1. WIDTH=8, INITIAL_VALUE=8'h05: hold i_rst_n=0 for 2 clocks with i_event=1 -> value=8'h05 and o_overflow=0 throughout. Release -> value increments by i_increment from the next edge.
2. value=8'hFE, SATURATE=0, i_increment=1, i_event=1 for 3 cycles -> value=FF, 00, 01. o_overflow=1 from the cycle value reaches 00 and stays set.
3. Same stimulus with SATURATE=1 -> value=FF, FF, FF. o_overflow=1 from the second cycle.
4. CLEAR_ON_READ=1, value=8'h10, read access plus i_event with i_increment=1 in the same cycle -> read_data=8'h10, next value=8'h01, o_overflow cleared.
5. value=8'h3C, write write_data=8'hA5 with write_mask=8'h0F plus i_event with i_increment=2 -> next value=8'h37. o_overflow unchanged.
6. i_clear together with a write and i_event at value=8'h80 -> value=INITIAL_VALUE and o_overflow=0. With RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN and i_threshold=8'h03, counting 0->3 -> o_threshold_hit pulses exactly once.

Source files
------------

// File: rtl/rggen_bit_field_counter_if.sv
// Register-decoder to bit-field access interface.
interface rggen_bit_field_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid, read_mask, write_mask, write_data,
    input  read_data, value
  );

  modport bit_field (
    input  valid, read_mask, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_counter.sv
// Software-accessible event counter bit field with clear-on-read, masked writes,
// wrap/saturate overflow and sticky overflow flag. Optional threshold pulse: RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN.
module rggen_bit_field_counter #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter int               INC_WIDTH     = 1,
  parameter bit               CLEAR_ON_READ = 1'b1,
  parameter bit               SATURATE      = 1'b0
)(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rggen_bit_field_if.bit_field bit_field_if,
  input  logic                 i_clear,
  input  logic                 i_event,
  input  logic [INC_WIDTH-1:0] i_increment,
  output logic [WIDTH-1:0]     o_value,
  output logic                 o_overflow
`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
  ,
  input  logic [WIDTH-1:0]     i_threshold,
  output logic                 o_threshold_hit
`endif
);

  logic [WIDTH-1:0] value_q;
  logic             overflow_q;
  logic             read_access;
  logic             write_access;
  logic             read_clear;
  logic [WIDTH-1:0] base_value;
  logic             base_overflow;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] next_value;
  logic             next_overflow;

  assign read_access  = bit_field_if.valid && (|bit_field_if.read_mask);
  assign write_access = bit_field_if.valid && (|bit_field_if.write_mask) &&
                        !(|bit_field_if.read_mask);
  assign read_clear   = read_access && CLEAR_ON_READ;
  assign inc_ext      = {{(WIDTH + 1 - INC_WIDTH){1'b0}}, i_increment};

  always_comb begin
    base_value    = value_q;
    base_overflow = overflow_q;
    if (read_clear) begin
      base_value    = '0;
      base_overflow = 1'b0;
    end else if (write_access) begin
      base_value = (bit_field_if.write_data & bit_field_if.write_mask) |
                   (value_q & ~bit_field_if.write_mask);
    end
  end

  // One extra bit catches the carry that signals a lost count.
  assign sum = {1'b0, base_value} + (i_event ? inc_ext : '0);

  always_comb begin
    next_value    = sum[WIDTH-1:0];
    next_overflow = base_overflow;
    if (i_clear) begin
      next_value    = INITIAL_VALUE;
      next_overflow = 1'b0;
    end else if (sum[WIDTH]) begin
      next_overflow = 1'b1;
      if (SATURATE) begin
        next_value = '1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      value_q    <= INITIAL_VALUE;
      overflow_q <= 1'b0;
    end else begin
      value_q    <= next_value;
      overflow_q <= next_overflow;
    end
  end

  assign o_value                = value_q;
  assign o_overflow             = overflow_q;
  assign bit_field_if.value     = value_q;
  assign bit_field_if.read_data = value_q;

`ifdef RGGEN_BIT_FIELD_COUNTER_THRESHOLD_EN
  logic threshold_hit_q;

  // Rising crossings only; clears never announce a crossing.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      threshold_hit_q <= 1'b0;
    end else begin
      threshold_hit_q <= !i_clear && !read_clear &&
                         (value_q < i_threshold) && (next_value >= i_threshold);
    end
  end

  assign o_threshold_hit = threshold_hit_q;
`endif

endmodule
